// File: rtl/keymap_translator_pkg.sv
// Shared types and constants for the layered keymap translator.
// Covers the FSM states, keymap layers, PS/2 scancodes and SPI flash opcodes.
package keymap_pkg;

    typedef enum logic [2:0] {
        ST_WAKE,
        ST_GAP,
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_WAIT,
        ST_REL
    } state_t;

    localparam logic [2:0] LAYER_BASE        = 3'd0;
    localparam logic [2:0] LAYER_SHIFT       = 3'd1;
    localparam logic [2:0] LAYER_ALTGR       = 3'd2;
    localparam logic [2:0] LAYER_ALTGR_SHIFT = 3'd3;
    localparam logic [2:0] LAYER_CTRL        = 3'd4;
    localparam logic [2:0] LAYER_EXT         = 3'd5;

    localparam logic [7:0] SC_E0     = 8'hE0;
    localparam logic [7:0] SC_F0     = 8'hF0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_LCTRL  = 8'h14;
    localparam logic [7:0] SC_ALT    = 8'h11;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    localparam logic [7:0] OP_WAKE = 8'hAB;
    localparam logic [7:0] OP_READ = 8'h03;

    function automatic logic [2:0] pick_layer(input logic e0, input logic ctrl,
                                              input logic altgr, input logic eff_shift);
        if (e0)                     return LAYER_EXT;
        else if (ctrl)              return LAYER_CTRL;
        else if (altgr && eff_shift) return LAYER_ALTGR_SHIFT;
        else if (altgr)             return LAYER_ALTGR;
        else if (eff_shift)         return LAYER_SHIFT;
        else                        return LAYER_BASE;
    endfunction

    // Flash address wraps modulo 2^24.
    function automatic logic [23:0] entry_addr(input logic [23:0] base, input int unsigned ebytes,
                                               input logic [2:0] layer, input logic [6:0] code);
        logic [31:0] off;
        off = ({29'd0, layer} * 32'd128 + {25'd0, code}) * ebytes;
        return base + off[23:0];
    endfunction

endpackage

// File: rtl/keymap_translator_if.sv
// Scancode input, SPI byte engine and output byte stream of the keymap translator.
interface keymap_translator_if;
    logic [7:0] sc_data;
    logic       sc_valid;
    logic [7:0] spi_tx_data;
    logic       spi_start;
    logic [7:0] spi_rx_data;
    logic       spi_complete;
    logic       spi_ss;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;

    modport slave (
        input  sc_data, sc_valid, spi_rx_data, spi_complete, out_ready,
        output spi_tx_data, spi_start, spi_ss, out_data, out_valid
    );

    modport master (
        output sc_data, sc_valid, spi_rx_data, spi_complete, out_ready,
        input  spi_tx_data, spi_start, spi_ss, out_data, out_valid
    );
endinterface

// File: rtl/keymap_translator_byte_fifo.sv
// Count-based synchronous FIFO; DEPTH must be a power of two (>= 2).
// A push on a full FIFO is accepted only when a pop happens in the same cycle.
module byte_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk100,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             din,
    input  logic                         pop,
    output logic [WIDTH-1:0]             dout,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             full, do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk100) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/keymap_translator.sv
// PS/2 scancode to character translator: tracks prefixes/modifiers, reads a
// multi-byte entry per make code from a layered keymap in SPI flash, queues the bytes.
module keymap_translator
    import keymap_pkg::*;
#(
    parameter logic [23:0] TABLE_BASE  = 24'h008000,
    parameter int          ENTRY_BYTES = 8,
    parameter int          SC_DEPTH    = 4,
    parameter int          OUT_DEPTH   = 16,
    parameter int          WAKE_GAP    = 400
) (
    input  logic                 clk100,
    input  logic                 rst_n,
    keymap_translator_if.slave   bus,
    output logic [4:0]           mods,
    output logic                 overflow
);
    localparam int SCW = $clog2(SC_DEPTH + 1);
    localparam int OCW = $clog2(OUT_DEPTH + 1);
    localparam int GW  = $clog2(WAKE_GAP + 1);

    state_t          state;
    logic            e0, brk, caps, ctrl, altgr, shift;
    logic [23:0]     addr;
    logic [1:0]      cmd_idx;
    logic            woke;
    logic [4:0]      n_rx;
    logic [GW-1:0]   gap_cnt;
    logic            ss_q, start_q;
    logic [7:0]      tx_q;

    logic [7:0]      sc_head, out_head;
    logic            sc_empty, out_empty, sc_pop, sc_full, sc_drop;
    logic [SCW-1:0]  sc_count;
    logic [OCW-1:0]  out_count;
    logic            out_push, out_pop, out_full, out_full_next, rx_end;

    byte_fifo #(.WIDTH(8), .DEPTH(SC_DEPTH)) u_sc_fifo (
        .clk100(clk100), .rst_n(rst_n),
        .push(bus.sc_valid), .din(bus.sc_data), .pop(sc_pop),
        .dout(sc_head), .empty(sc_empty), .count(sc_count)
    );

    byte_fifo #(.WIDTH(8), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk100(clk100), .rst_n(rst_n),
        .push(out_push), .din(bus.spi_rx_data), .pop(out_pop),
        .dout(out_head), .empty(out_empty), .count(out_count)
    );

    assign sc_pop   = (state == ST_IDLE) && !sc_empty;
    assign sc_full  = (sc_count == SCW'(SC_DEPTH));
    assign sc_drop  = bus.sc_valid && sc_full && !sc_pop;
    assign rx_end   = (bus.spi_rx_data == 8'h00) || (bus.spi_rx_data == 8'hFF);
    assign out_push = (state == ST_DATA) && bus.spi_complete && !rx_end;
    assign out_pop  = bus.out_ready && !out_empty;
    assign out_full = (out_count == OCW'(OUT_DEPTH));
    // Occupancy after this cycle's push, used to decide on the next start a cycle early.
    assign out_full_next = (out_count == OCW'(OUT_DEPTH - 1)) && !out_pop;

    assign bus.spi_tx_data = tx_q;
    assign bus.spi_start   = start_q;
    assign bus.spi_ss      = ss_q;
    assign bus.out_data    = out_head;
    assign bus.out_valid   = !out_empty;
    assign mods            = {e0, caps, ctrl, altgr, shift};

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_WAKE;
            ss_q     <= 1'b1;
            start_q  <= 1'b0;
            tx_q     <= '0;
            e0       <= 1'b0;
            brk      <= 1'b0;
            caps     <= 1'b0;
            ctrl     <= 1'b0;
            altgr    <= 1'b0;
            shift    <= 1'b0;
            addr     <= '0;
            cmd_idx  <= '0;
            woke     <= 1'b0;
            n_rx     <= '0;
            gap_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            start_q <= 1'b0;
            if (sc_drop) overflow <= 1'b1;
            case (state)
                ST_WAKE: begin
                    if (!woke) begin
                        woke    <= 1'b1;
                        ss_q    <= 1'b0;
                        start_q <= 1'b1;
                        tx_q    <= OP_WAKE;
                    end else if (bus.spi_complete) begin
                        ss_q    <= 1'b1;
                        gap_cnt <= '0;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == GW'(WAKE_GAP - 1)) state <= ST_IDLE;
                    else gap_cnt <= gap_cnt + 1'b1;
                end
                ST_IDLE: begin
                    if (sc_pop) begin
                        if (sc_head == SC_E0) begin
                            e0 <= 1'b1;
                        end else if (sc_head == SC_F0) begin
                            brk <= 1'b1;
                        end else begin
                            e0  <= 1'b0;
                            brk <= 1'b0;
                            if (sc_head == SC_LSHIFT || sc_head == SC_RSHIFT) begin
                                shift <= !brk;
                            end else if (sc_head == SC_LCTRL) begin
                                ctrl <= !brk;
                            end else if (sc_head == SC_ALT && e0) begin
                                altgr <= !brk;
                            end else if (sc_head == SC_CAPS) begin
                                if (!brk) caps <= !caps;
                            end else if (!brk && !sc_head[7]) begin
                                addr    <= entry_addr(TABLE_BASE, ENTRY_BYTES,
                                                      pick_layer(e0, ctrl, altgr, shift ^ caps),
                                                      sc_head[6:0]);
                                ss_q    <= 1'b0;
                                start_q <= 1'b1;
                                tx_q    <= OP_READ;
                                cmd_idx <= '0;
                                state   <= ST_CMD;
                            end
                        end
                    end
                end
                ST_CMD: begin
                    if (bus.spi_complete) begin
                        start_q <= 1'b1;
                        if (cmd_idx == 2'd3) begin
                            tx_q  <= 8'h00;
                            n_rx  <= '0;
                            state <= ST_DATA;
                        end else begin
                            cmd_idx <= cmd_idx + 1'b1;
                            case (cmd_idx)
                                2'd0:    tx_q <= addr[23:16];
                                2'd1:    tx_q <= addr[15:8];
                                default: tx_q <= addr[7:0];
                            endcase
                        end
                    end
                end
                ST_DATA: begin
                    if (bus.spi_complete) begin
                        if (rx_end || (n_rx + 5'd1 == 5'(ENTRY_BYTES))) begin
                            ss_q  <= 1'b1;
                            state <= ST_REL;
                        end else begin
                            n_rx <= n_rx + 5'd1;
                            if (out_full_next) begin
                                state <= ST_WAIT;
                            end else begin
                                start_q <= 1'b1;
                                tx_q    <= 8'h00;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (!out_full) begin
                        start_q <= 1'b1;
                        tx_q    <= 8'h00;
                        state   <= ST_DATA;
                    end
                end
                ST_REL:  state <= ST_IDLE;
                default: state <= ST_WAKE;
            endcase
        end
    end
endmodule

// File: tb/tb_keymap_translator.sv
// Scoreboard bench for keymap_translator with a behavioural SPI flash responder.
module tb_keymap_translator;
    logic       clk100 = 1'b0;
    logic       rst_n;
    logic [4:0] mods;
    logic       overflow;

    keymap_translator_if bus();

    keymap_translator #(
        .TABLE_BASE(24'h008000), .ENTRY_BYTES(8), .SC_DEPTH(4),
        .OUT_DEPTH(4), .WAKE_GAP(400)
    ) dut (
        .clk100(clk100), .rst_n(rst_n), .bus(bus), .mods(mods), .overflow(overflow)
    );

    always #5 clk100 = ~clk100;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_spi[$];
    logic [7:0] exp_out[$];
    logic [7:0] rx_q[$];
    int         xfer_idx;
    logic [7:0] flash_r;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic expect_lookup(input logic [23:0] a, input int ndata);
        exp_spi.push_back(8'h03);
        exp_spi.push_back(a[23:16]);
        exp_spi.push_back(a[15:8]);
        exp_spi.push_back(a[7:0]);
        for (int i = 0; i < ndata; i++) exp_spi.push_back(8'h00);
    endtask

    // One entry: a single character followed by the 0x00 terminator.
    task automatic one_char(input logic [23:0] a, input logic [7:0] ch);
        expect_lookup(a, 2);
        rx_q.push_back(ch);
        rx_q.push_back(8'h00);
        exp_out.push_back(ch);
    endtask

    task automatic send_sc(input logic [7:0] b);
        @(posedge clk100); #1;
        bus.sc_data  = b;
        bus.sc_valid = 1'b1;
        @(posedge clk100); #1;
        bus.sc_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (k < 4000 && !(exp_spi.size() == 0 && exp_out.size() == 0 && bus.spi_ss)) begin
            @(negedge clk100);
            k++;
        end
        if (k >= 4000) begin
            total++;
            bad++;
            $display("FAIL %s timeout: spi_left=%0d out_left=%0d want 0", name, exp_spi.size(), exp_out.size());
        end
        repeat (10) @(negedge clk100);
    endtask

    // Flash: answers each start two cycles later; data bytes only after the 4-byte read header.
    initial begin
        bus.spi_complete = 1'b0;
        bus.spi_rx_data  = 8'h00;
        xfer_idx = 0;
        forever begin
            @(negedge clk100);
            if (bus.spi_ss) xfer_idx = 0;
            if (bus.spi_start) begin
                if (xfer_idx >= 4 && rx_q.size() > 0) flash_r = rx_q.pop_front();
                else flash_r = 8'h00;
                xfer_idx++;
                repeat (2) @(posedge clk100);
                #1;
                bus.spi_rx_data  = flash_r;
                bus.spi_complete = 1'b1;
                @(posedge clk100); #1;
                bus.spi_complete = 1'b0;
            end
        end
    end

    // Monitor: every SPI start and every output pop is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge clk100);
            if (bus.spi_start) begin
                if (exp_spi.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spi_byte: got unexpected %0h want none", bus.spi_tx_data);
                end else begin
                    check("spi_byte", {24'd0, bus.spi_tx_data}, {24'd0, exp_spi.pop_front()});
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_out.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_byte: got unexpected %0h want none", bus.out_data);
                end else begin
                    check("out_byte", {24'd0, bus.out_data}, {24'd0, exp_out.pop_front()});
                end
            end
        end
    end

    initial begin
        int k;
        int cnt;
        rst_n         = 1'b0;
        bus.sc_valid  = 1'b0;
        bus.sc_data   = 8'h00;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk100);
        check("rst_ss", {31'd0, bus.spi_ss}, 32'd1);
        check("rst_start", {31'd0, bus.spi_start}, 32'd0);
        check("rst_tx", {24'd0, bus.spi_tx_data}, 32'd0);
        check("rst_mods", {27'd0, mods}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);

        // Wake command, gap length, then first lookup queued during WAKE.
        exp_spi.push_back(8'hAB);
        one_char(24'h0080E0, 8'h61);
        @(posedge clk100); #1 rst_n = 1'b1;
        k = 0;
        while (!bus.spi_start && k < 100) begin @(negedge clk100); k++; end
        check("wake_ss_low", {31'd0, bus.spi_ss}, 32'd0);
        send_sc(8'h1C);
        k = 0;
        while (!bus.spi_ss && k < 100) begin @(negedge clk100); k++; end
        cnt = 0;
        while (bus.spi_ss && cnt < 2000) begin cnt++; @(negedge clk100); end
        check("gap_plus_idle_cycles", cnt, 32'd401);
        wait_done("first_key");
        check("mods_plain", {27'd0, mods}, 32'd0);

        // Shift layer, then caps (break of caps ignored), then caps off + shift.
        one_char(24'h0084E0, 8'h41);
        send_sc(8'h12); send_sc(8'h1C); send_sc(8'hF0); send_sc(8'h12);
        wait_done("shift_key");
        check("mods_shift_released", {27'd0, mods}, 32'd0);
        one_char(24'h0084E0, 8'h42);
        send_sc(8'h58); send_sc(8'hF0); send_sc(8'h58); send_sc(8'h1C);
        wait_done("caps_key");
        check("mods_caps", {27'd0, mods}, 32'h08);
        one_char(24'h0084E0, 8'h43);
        send_sc(8'h58); send_sc(8'h12); send_sc(8'h1C);
        wait_done("caps_off_shift_key");
        check("mods_shift", {27'd0, mods}, 32'h01);

        // AltGr + shift (layer 3); release both; extended key (layer 5); ctrl (layer 4).
        one_char(24'h008CE0, 8'h44);
        send_sc(8'hE0); send_sc(8'h11); send_sc(8'h1C);
        wait_done("altgr_shift_key");
        check("mods_altgr_shift", {27'd0, mods}, 32'h03);
        send_sc(8'hF0); send_sc(8'h12); send_sc(8'hE0); send_sc(8'hF0);
        send_sc(8'h11);
        wait_done("altgr_release");
        check("mods_released", {27'd0, mods}, 32'd0);
        one_char(24'h009650, 8'h2F);
        send_sc(8'hE0); send_sc(8'h4A);
        wait_done("ext_key");
        one_char(24'h0090E0, 8'h01);
        send_sc(8'h14); send_sc(8'h1C);
        wait_done("ctrl_key");
        check("mods_ctrl", {27'd0, mods}, 32'h04);
        send_sc(8'hF0); send_sc(8'h14);
        // Break of a plain key and a make >= 0x80 launch nothing.
        send_sc(8'hF0); send_sc(8'h1C); send_sc(8'h83);
        wait_done("discards");
        check("mods_after_discards", {27'd0, mods}, 32'd0);

        // Full 8-byte entry into a 4-deep output FIFO with the consumer stalled.
        bus.out_ready = 1'b0;
        expect_lookup(24'h0080E0, 8);
        for (int i = 0; i < 8; i++) begin
            rx_q.push_back(8'h30 + 8'(i));
            exp_out.push_back(8'h30 + 8'(i));
        end
        send_sc(8'h1C);
        k = 0;
        while (exp_spi.size() > 4 && k < 500) begin @(negedge clk100); k++; end
        repeat (30) @(negedge clk100);
        check("wait_spi_left", exp_spi.size(), 32'd4);
        check("wait_ss_low", {31'd0, bus.spi_ss}, 32'd0);
        check("wait_out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("wait_out_head", {24'd0, bus.out_data}, 32'h30);
        @(posedge clk100); #1 bus.out_ready = 1'b1;
        wait_done("stall_resume");

        // Six scancodes during CMD into a 4-deep scancode FIFO: last two dropped.
        one_char(24'h0080E0, 8'h61);
        one_char(24'h0080E0, 8'h62);
        one_char(24'h008190, 8'h63);
        one_char(24'h008108, 8'h64);
        one_char(24'h008118, 8'h65);
        send_sc(8'h1C);
        k = 0;
        while (bus.spi_ss && k < 100) begin @(negedge clk100); k++; end
        check("overflow_before_burst", {31'd0, overflow}, 32'd0);
        begin
            logic [7:0] burst [6];
            burst = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h2B, 8'h34};
            for (int i = 0; i < 6; i++) begin
                @(posedge clk100); #1;
                bus.sc_data  = burst[i];
                bus.sc_valid = 1'b1;
            end
            @(posedge clk100); #1 bus.sc_valid = 1'b0;
        end
        @(negedge clk100);
        check("overflow_set", {31'd0, overflow}, 32'd1);
        wait_done("burst_keys");
        check("overflow_sticky", {31'd0, overflow}, 32'd1);
        check("rx_all_consumed", rx_q.size(), 32'd0);

        // Asynchronous reset in the middle of a data phase.
        bus.out_ready = 1'b0;
        expect_lookup(24'h0080E0, 8);
        for (int i = 0; i < 8; i++) begin
            rx_q.push_back(8'h70 + 8'(i));
            exp_out.push_back(8'h70 + 8'(i));
        end
        send_sc(8'h1C);
        k = 0;
        while (exp_spi.size() > 5 && k < 500) begin @(negedge clk100); k++; end
        repeat (4) @(negedge clk100);
        check("mid_data_out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("mid_data_ss", {31'd0, bus.spi_ss}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("arst_ss", {31'd0, bus.spi_ss}, 32'd1);
        check("arst_overflow", {31'd0, overflow}, 32'd0);
        check("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("arst_start", {31'd0, bus.spi_start}, 32'd0);
        exp_spi.delete();
        exp_out.delete();
        rx_q.delete();
        repeat (10) @(negedge clk100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
